// File: rtl/udp_tx_payload_reader_pkg.sv
// Shared types and helpers for the UDP TX payload read path:
// FSM states, FIFO geometry and the ones'-complement adder.
package udp_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tx_state_t;

    localparam int FIFO_DATA_WIDTH = 32;
    localparam int FIFO_RD_LATENCY = 1;

    // End-around carry add; a single fold is enough because 0xFFFF+0xFFFF folds to 0xFFFF
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/udp_tx_payload_reader_csum16_acc.sv
// Byte-pair ones'-complement accumulator: even bytes form the high half of each
// 16-bit word, and a lone final byte is padded with a zero low byte.
module udp_csum16_acc
    import udp_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        last,
    output logic [15:0] sum
);

    logic [7:0] hi_byte;
    logic       have_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum     <= 16'h0000;
            hi_byte <= 8'h00;
            have_hi <= 1'b0;
        end else if (clear) begin
            sum     <= 16'h0000;
            hi_byte <= 8'h00;
            have_hi <= 1'b0;
        end else if (byte_valid) begin
            if (have_hi) begin
                sum     <= ones_add(sum, {hi_byte, byte_data});
                have_hi <= 1'b0;
            end else if (last) begin
                sum <= ones_add(sum, {byte_data, 8'h00});
            end else begin
                hi_byte <= byte_data;
                have_hi <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_tx_payload_reader.sv
// Pops ceil(len/4) words from the payload FIFO and streams them big-endian as bytes,
// with a holding register plus one prefetch slot so words join without bubbles.
module udp_tx_payload_reader
    import udp_tx_pkg::*;
#(
    parameter int MAX_LEN   = 1472,
    parameter int LEN_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tx_start,
    input  logic [LEN_WIDTH-1:0]       tx_len,
    output logic                       busy,
    output logic                       len_err,
    output logic                       fifo_rd_en,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                       fifo_rd_empty,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       tx_last,
    output logic [15:0]                csum_sum,
    output logic                       csum_valid
);

    localparam logic [LEN_WIDTH-1:0] MAX_LEN_W = LEN_WIDTH'(MAX_LEN);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);

    tx_state_t                  state;
    logic [LEN_WIDTH-1:0]       words_left;
    logic [LEN_WIDTH-1:0]       bytes_left;
    logic [FIFO_DATA_WIDTH-1:0] hold_reg;
    logic [FIFO_DATA_WIDTH-1:0] pre_reg;
    logic [2:0]                 hold_cnt;
    logic                       pre_valid;
    logic [FIFO_RD_LATENCY-1:0] rd_inflight;

    logic                       len_ok;
    logic                       accept;
    logic                       xfer;
    logic                       hold_empties;
    logic                       pre_drains;
    logic [LEN_WIDTH:0]         len_plus3;

    assign len_ok    = (tx_len != '0) && (tx_len <= MAX_LEN_W);
    assign accept    = (state == IDLE) && tx_start && len_ok;
    assign len_plus3 = {1'b0, tx_len} + {{(LEN_WIDTH-1){1'b0}}, 2'b11};

    assign tx_valid = (state == RUN) && (hold_cnt != 3'd0);
    assign tx_data  = hold_reg[31:24];
    assign tx_last  = tx_valid && (bytes_left == LEN_ONE);
    assign xfer     = tx_valid && tx_ready;

    // The holding register is free this cycle if it is empty or its final byte leaves now
    assign hold_empties = (hold_cnt == 3'd0) || ((hold_cnt == 3'd1) && xfer);
    assign pre_drains   = pre_valid && hold_empties;

    assign fifo_rd_en = (state == RUN) && (words_left != '0) && !fifo_rd_empty &&
                        (!pre_valid || pre_drains) && !rd_inflight[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            len_err     <= 1'b0;
            csum_valid  <= 1'b0;
            words_left  <= '0;
            bytes_left  <= '0;
            hold_reg    <= '0;
            pre_reg     <= '0;
            hold_cnt    <= 3'd0;
            pre_valid   <= 1'b0;
            rd_inflight <= '0;
        end else begin
            len_err    <= 1'b0;
            csum_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        if (len_ok) begin
                            state       <= RUN;
                            busy        <= 1'b1;
                            words_left  <= {1'b0, len_plus3[LEN_WIDTH:2]};
                            bytes_left  <= tx_len;
                            hold_cnt    <= 3'd0;
                            pre_valid   <= 1'b0;
                            rd_inflight <= '0;
                        end else begin
                            len_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fifo_rd_en) begin
                        words_left <= words_left - LEN_ONE;
                    end
                    rd_inflight <= fifo_rd_en;
                    if (xfer) begin
                        bytes_left <= bytes_left - LEN_ONE;
                    end
                    if (xfer && tx_last) begin
                        // Leftover bytes of a partial last word are simply dropped here
                        state       <= DONE;
                        busy        <= 1'b0;
                        csum_valid  <= 1'b1;
                        hold_cnt    <= 3'd0;
                        pre_valid   <= 1'b0;
                        rd_inflight <= '0;
                    end else begin
                        if (hold_empties) begin
                            if (pre_valid) begin
                                hold_reg <= pre_reg;
                                hold_cnt <= 3'd4;
                            end else if (rd_inflight[0]) begin
                                hold_reg <= fifo_rd_data;
                                hold_cnt <= 3'd4;
                            end else begin
                                hold_cnt <= 3'd0;
                            end
                        end else if (xfer) begin
                            hold_reg <= {hold_reg[23:0], 8'h00};
                            hold_cnt <= hold_cnt - 3'd1;
                        end
                        if (rd_inflight[0] && !(hold_empties && !pre_valid)) begin
                            pre_reg   <= fifo_rd_data;
                            pre_valid <= 1'b1;
                        end else if (pre_drains) begin
                            pre_valid <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    udp_csum16_acc u_csum (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (accept),
        .byte_valid (xfer),
        .byte_data  (tx_data),
        .last       (tx_last),
        .sum        (csum_sum)
    );

endmodule
